// File: rtl/rx_frame_dispatch.sv
// Ethernet rx dispatcher: captures the header, filters on destination MAC and routes by EtherType.
// Optional statistics counters are enabled with the RX_DISPATCH_STATS_EN macro.
module rx_frame_dispatch #(
    parameter int          P_HDR_LEN = 14,
    parameter logic [15:0] P_ETYPE_A = 16'h0806,
    parameter logic [15:0] P_ETYPE_B = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] cfg_mac,
    input  logic [7:0]  in_byte,
    input  logic        in_byte_vld,
    output logic        in_byte_rdy,
    input  logic        in_sof,
    input  logic        in_eof,
`ifdef RX_DISPATCH_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_a_cnt,
    output logic [15:0] stat_b_cnt,
    output logic [15:0] stat_drop_cnt,
    output logic [15:0] stat_runt_cnt,
`endif
    output logic [7:0]  a_byte,
    output logic        a_vld,
    input  logic        a_rdy,
    output logic        a_sof,
    output logic        a_eof,
    output logic [7:0]  b_byte,
    output logic        b_vld,
    input  logic        b_rdy,
    output logic        b_sof,
    output logic        b_eof
);

    localparam int IDX_W = $clog2(P_HDR_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_HDR_LEN - 1);

    typedef enum logic [2:0] {IDLE, HDR, DECIDE, REPLAY, STREAM, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [7:0]       hdr [0:P_HDR_LEN-1];
    logic [IDX_W-1:0] hdr_idx;
    logic [IDX_W-1:0] rep_idx;
    logic [7:0]       rep_byte;
    logic             rep_sof, rep_eof;
    logic             eof_in_hdr;
    logic             sel_a;
    logic             rdy_c, runt_evt;
    logic [7:0]       sel_byte;
    logic             sel_vld, sel_sof, sel_eof, sel_rdy;
    logic [47:0]      dst_mac;
    logic [15:0]      etype;
    logic             dst_ok, dec_a, dec_b;

    assign dst_mac = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]};
    assign etype   = {hdr[P_HDR_LEN-2], hdr[P_HDR_LEN-1]};
    assign dst_ok  = (dst_mac == cfg_mac) || (dst_mac == 48'hFFFF_FFFF_FFFF);
    assign dec_a   = dst_ok && (etype == P_ETYPE_A);
    assign dec_b   = dst_ok && (etype == P_ETYPE_B);
    assign sel_rdy = sel_a ? a_rdy : b_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy_c     = 1'b0;
        runt_evt  = 1'b0;
        sel_byte  = 8'h00;
        sel_vld   = 1'b0;
        sel_sof   = 1'b0;
        sel_eof   = 1'b0;
        case (state)
            IDLE: begin
                rdy_c = 1'b1;
                if (in_byte_vld && in_sof) begin
                    if (in_eof) runt_evt  = 1'b1;
                    else        state_nxt = HDR;
                end
            end
            HDR: begin
                rdy_c = 1'b1;
                if (in_byte_vld) begin
                    if (in_sof) begin
                        if (in_eof) begin
                            runt_evt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if (hdr_idx == LAST_IDX) begin
                        state_nxt = DECIDE;
                    end else if (in_eof) begin
                        runt_evt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DECIDE: begin
                if (dec_a || dec_b) state_nxt = REPLAY;
                else                state_nxt = eof_in_hdr ? IDLE : DRAIN;
            end
            REPLAY: begin
                sel_byte = rep_byte;
                sel_vld  = 1'b1;
                sel_sof  = rep_sof;
                sel_eof  = rep_eof;
                if (sel_rdy && rep_idx == LAST_IDX)
                    state_nxt = eof_in_hdr ? IDLE : STREAM;
            end
            STREAM: begin
                sel_byte = in_byte;
                sel_vld  = in_byte_vld;
                sel_eof  = in_eof;
                rdy_c    = sel_rdy;
                if (in_byte_vld && sel_rdy && in_eof) state_nxt = IDLE;
            end
            DRAIN: begin
                rdy_c = 1'b1;
                if (in_byte_vld && in_eof) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pop is forced low while reset is held, even though IDLE would otherwise accept.
    assign in_byte_rdy = rst_n & rdy_c;

    assign a_vld  = sel_a & sel_vld;
    assign a_sof  = sel_a & sel_sof;
    assign a_eof  = sel_a & sel_eof;
    assign a_byte = sel_a ? sel_byte : 8'h00;
    assign b_vld  = ~sel_a & sel_vld;
    assign b_sof  = ~sel_a & sel_sof;
    assign b_eof  = ~sel_a & sel_eof;
    assign b_byte = sel_a ? 8'h00 : sel_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_HDR_LEN; i++) hdr[i] <= 8'h00;
            hdr_idx    <= '0;
            rep_idx    <= '0;
            rep_byte   <= 8'h00;
            rep_sof    <= 1'b0;
            rep_eof    <= 1'b0;
            eof_in_hdr <= 1'b0;
            sel_a      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_byte_vld && in_sof) hdr[0] <= in_byte;
                    hdr_idx <= (in_byte_vld && in_sof && !in_eof) ? IDX_W'(1) : '0;
                end
                HDR: if (in_byte_vld) begin
                    if (in_sof) begin
                        hdr[0]  <= in_byte;
                        hdr_idx <= IDX_W'(1);
                    end else begin
                        hdr[hdr_idx] <= in_byte;
                        hdr_idx      <= hdr_idx + IDX_W'(1);
                        if (hdr_idx == LAST_IDX) eof_in_hdr <= in_eof;
                    end
                end
                DECIDE: begin
                    hdr_idx  <= '0;
                    sel_a    <= dec_a;
                    rep_idx  <= '0;
                    rep_byte <= hdr[0];
                    rep_sof  <= 1'b1;
                    rep_eof  <= 1'b0;
                end
                REPLAY: if (sel_rdy && rep_idx != LAST_IDX) begin
                    rep_idx  <= rep_idx + IDX_W'(1);
                    rep_byte <= hdr[rep_idx + IDX_W'(1)];
                    rep_sof  <= 1'b0;
                    rep_eof  <= eof_in_hdr && (rep_idx + IDX_W'(1) == LAST_IDX);
                end
                default: ;
            endcase
        end
    end

`ifdef RX_DISPATCH_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || stat_clr) begin
            stat_a_cnt    <= 16'h0;
            stat_b_cnt    <= 16'h0;
            stat_drop_cnt <= 16'h0;
            stat_runt_cnt <= 16'h0;
        end else begin
            if (state == DECIDE && dec_a)             stat_a_cnt    <= sat_inc(stat_a_cnt);
            if (state == DECIDE && dec_b)             stat_b_cnt    <= sat_inc(stat_b_cnt);
            if (state == DECIDE && !dec_a && !dec_b)  stat_drop_cnt <= sat_inc(stat_drop_cnt);
            if (runt_evt)                             stat_runt_cnt <= sat_inc(stat_runt_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_dispatch.sv
// Scoreboard bench for rx_frame_dispatch: expected sink bytes are queued as frames are driven.
module tb_rx_frame_dispatch;

    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h02_99_88_77_66_55;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] cfg_mac = MAC;
    logic [7:0]  in_byte = 8'h00;
    logic        in_byte_vld = 1'b0, in_sof = 1'b0, in_eof = 1'b0;
    logic        in_byte_rdy;
    logic [7:0]  a_byte, b_byte;
    logic        a_vld, a_sof, a_eof, b_vld, b_sof, b_eof;
    logic        a_rdy = 1'b1, b_rdy = 1'b1;
`ifdef RX_DISPATCH_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_a_cnt, stat_b_cnt, stat_drop_cnt, stat_runt_cnt;
`endif

    rx_frame_dispatch dut (
        .clk(clk), .rst_n(rst_n), .cfg_mac(cfg_mac),
        .in_byte(in_byte), .in_byte_vld(in_byte_vld), .in_byte_rdy(in_byte_rdy),
        .in_sof(in_sof), .in_eof(in_eof),
`ifdef RX_DISPATCH_STATS_EN
        .stat_clr(stat_clr), .stat_a_cnt(stat_a_cnt), .stat_b_cnt(stat_b_cnt),
        .stat_drop_cnt(stat_drop_cnt), .stat_runt_cnt(stat_runt_cnt),
`endif
        .a_byte(a_byte), .a_vld(a_vld), .a_rdy(a_rdy), .a_sof(a_sof), .a_eof(a_eof),
        .b_byte(b_byte), .b_vld(b_vld), .b_rdy(b_rdy), .b_sof(b_sof), .b_eof(b_eof)
    );

    always #5 clk = ~clk;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         accepted = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [7:0] frame[$];
    logic       tog_en = 1'b0;
    logic       b_stall_prev = 1'b0;
    logic [7:0] b_byte_prev = 8'h00;

    always @(posedge clk) if (tog_en) begin
        #1;
        b_rdy = ~b_rdy;
    end

    // Scoreboard monitor: sink transfers complete at the next rising edge.
    always @(negedge clk) begin
        logic [9:0] exp_e;
        if (!rst_n) begin
            b_stall_prev = 1'b0;
        end else begin
            if (b_stall_prev) begin
                tests_run++;
                if (b_vld !== 1'b1 || b_byte !== b_byte_prev) begin
                    tests_failed++;
                    $display("FAIL b_stall_hold: vld=%b byte=%h, required vld=1 byte=%h", b_vld, b_byte, b_byte_prev);
                end
            end
            b_stall_prev = b_vld && !b_rdy;
            b_byte_prev  = b_byte;
            if (a_vld) begin
                if (qa.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("FAIL a_unexpected: a_vld=1 byte=%h, required no output", a_byte);
                end else if (a_rdy) begin
                    exp_e = qa.pop_front();
                    tests_run++;
                    if ({a_sof, a_eof, a_byte} !== exp_e) begin
                        tests_failed++;
                        $display("FAIL a_data: got sof/eof/byte=%b/%b/%h, required %b/%b/%h",
                                 a_sof, a_eof, a_byte, exp_e[9], exp_e[8], exp_e[7:0]);
                    end
                end
            end
            if (b_vld) begin
                if (qb.size() == 0) begin
                    tests_run++; tests_failed++;
                    $display("FAIL b_unexpected: b_vld=1 byte=%h, required no output", b_byte);
                end else if (b_rdy) begin
                    exp_e = qb.pop_front();
                    tests_run++;
                    if ({b_sof, b_eof, b_byte} !== exp_e) begin
                        tests_failed++;
                        $display("FAIL b_data: got sof/eof/byte=%b/%b/%h, required %b/%b/%h",
                                 b_sof, b_eof, b_byte, exp_e[9], exp_e[8], exp_e[7:0]);
                    end
                end
            end
        end
    end

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input int len);
        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(8'(8'hA0 + i));
        frame.push_back(et[15:8]);
        frame.push_back(et[7:0]);
        while (frame.size() < len) frame.push_back(8'($urandom_range(255)));
        while (frame.size() > len) void'(frame.pop_back());
    endtask

    task automatic expect_frame(input int sink, input int n);
        for (int i = 0; i < n; i++) begin
            if (sink == 1) qa.push_back({i == 0, i == frame.size() - 1, frame[i]});
            else           qb.push_back({i == 0, i == frame.size() - 1, frame[i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
        int n;
        in_byte = b; in_sof = s; in_eof = e; in_byte_vld = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_byte_rdy) break;
            n++;
            if (n > 2000) begin
                tests_failed++;
                $display("FAIL send_timeout: in_byte_rdy=%b after %0d cycles, required 1", in_byte_rdy, n);
                $fatal(1, "handshake timeout");
            end
        end
        @(posedge clk);
        #1;
        accepted++;
        in_byte_vld = 1'b0;
        if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < frame.size(); i++)
            send_byte(frame[i], i == 0, i == frame.size() - 1);
        in_sof = 1'b0; in_eof = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (qa.size() != 0 || qb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: pending a=%0d b=%0d, required 0/0", name, qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({in_byte_rdy, a_vld, b_vld, a_sof, b_eof, a_byte, b_byte} !== 21'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: rdy=%b a_vld=%b b_vld=%b a=%h b=%h, required all 0",
                     in_byte_rdy, a_vld, b_vld, a_byte, b_byte);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_byte_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_rdy: got %b, required 1", in_byte_rdy);
        end
    endtask

    task automatic test_arp_bcast();
        build(BCAST, 16'h0806, 60);
        expect_frame(1, 60);
        send_frame();
        wait_drain("arp_bcast");
    endtask

    task automatic test_ipv4_stall();
        build(MAC, 16'h0800, 100);
        expect_frame(2, 100);
        tog_en = 1'b1;
        send_frame();
        wait_drain("ipv4_stall");
        @(posedge clk);
        tog_en = 1'b0;
        #2;
        b_rdy = 1'b1;
    endtask

    task automatic test_drop();
        accepted = 0;
        build(OTHER, 16'h0800, 80);
        send_frame();
        wait_drain("drop");
        tests_run++;
        if (accepted !== 80) begin
            tests_failed++;
            $display("FAIL drop_popped: got %0d, required 80", accepted);
        end
`ifdef RX_DISPATCH_STATS_EN
        tests_run++;
        if (stat_drop_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL stat_drop: got %0d, required 1", stat_drop_cnt);
        end
`endif
    endtask

    task automatic test_runt();
        build(MAC, 16'h0806, 10);
        send_frame();
        build(MAC, 16'h0806, 40);
        expect_frame(1, 40);
        send_frame();
        wait_drain("runt");
`ifdef RX_DISPATCH_STATS_EN
        tests_run++;
        if (stat_runt_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL stat_runt: got %0d, required 1", stat_runt_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        build(MAC, 16'h0800, 14);
        expect_frame(2, 14);
        send_frame();
        build(BCAST, 16'h0806, 20);
        expect_frame(1, 20);
        send_frame();
        wait_drain("exact14_b2b");
`ifdef RX_DISPATCH_STATS_EN
        tests_run++;
        if ({stat_a_cnt, stat_b_cnt, stat_drop_cnt, stat_runt_cnt} !== {16'd3, 16'd2, 16'd1, 16'd1}) begin
            tests_failed++;
            $display("FAIL stat_totals: a/b/drop/runt=%0d/%0d/%0d/%0d, required 3/2/1/1",
                     stat_a_cnt, stat_b_cnt, stat_drop_cnt, stat_runt_cnt);
        end
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        tests_run++;
        if ({stat_a_cnt, stat_b_cnt, stat_drop_cnt, stat_runt_cnt} !== 64'h0) begin
            tests_failed++;
            $display("FAIL stat_clr: a/b/drop/runt=%0d/%0d/%0d/%0d, required 0",
                     stat_a_cnt, stat_b_cnt, stat_drop_cnt, stat_runt_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_stream();
        build(MAC, 16'h0800, 64);
        for (int i = 0; i < 30; i++) qb.push_back({i == 0, 1'b0, frame[i]});
        for (int i = 0; i < 30; i++) send_byte(frame[i], i == 0, 1'b0);
        in_byte = frame[30]; in_sof = 1'b0; in_eof = 1'b0; in_byte_vld = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({a_vld, b_vld, in_byte_rdy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid_async: a_vld=%b b_vld=%b rdy=%b, required 000", a_vld, b_vld, in_byte_rdy);
        end
        in_byte_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (qb.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_delivered: pending %0d, required 0", qb.size());
            qb.delete();
        end
        build(BCAST, 16'h0806, 30);
        expect_frame(1, 30);
        send_frame();
        wait_drain("after_reset");
`ifdef RX_DISPATCH_STATS_EN
        tests_run++;
        if (stat_a_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL stat_after_reset: got %0d, required 1", stat_a_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_arp_bcast();
        test_ipv4_stall();
        test_drop();
        test_runt();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
